// File: rtl/deadlock_mon_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | deadlock_mon_pkg : shared FSM state type and default sizing for the      |
// |                    deadlock/stall watchdog.                              |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
package deadlock_mon_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WATCH   = 2'd1,
    ST_BLOCKED = 2'd2
  } state_e;

  localparam int c_DEF_N_AXIS = 4;
  localparam int c_DEF_N_INST = 4;
  localparam int c_DEF_CNT_W  = 16;
  localparam int c_DEF_EVT_W  = 8;

endpackage
`default_nettype wire

// File: rtl/stall_prio_enc.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | stall_prio_enc : lowest-index-first priority encoder over a stall vector.|
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module stall_prio_enc #(
  parameter int W     = 8,
  parameter int IDX_W = 3
) (
  input  logic [W-1:0]     vec_i,
  output logic [IDX_W-1:0] first_o
);

  // Scan from the top down so the lowest set bit is the last writer.
  always_comb begin
    first_o = '0;
    for (int i = W - 1; i >= 0; i--) begin
      if (vec_i[i]) first_o = IDX_W'(i);
    end
  end

endmodule
`default_nettype wire

// File: rtl/deadlock_stall_watchdog.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | deadlock_stall_watchdog : declares a deadlock when a non-idle stall      |
// |                           vector persists unchanged for threshold cycles.|
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module deadlock_stall_watchdog
  import deadlock_mon_pkg::*;
#(
  parameter int  N_AXIS = c_DEF_N_AXIS,
  parameter int  N_INST = c_DEF_N_INST,
  parameter int  CNT_W  = c_DEF_CNT_W,
  parameter int  EVT_W  = c_DEF_EVT_W,
  localparam int N_TOT  = N_AXIS + N_INST,
  localparam int FC_W   = (N_TOT > 1) ? $clog2(N_TOT) : 1
) (
  input  logic              kernel_monitor_clock,
  input  logic              kernel_monitor_reset,
  input  logic [N_AXIS-1:0] axis_block_sigs,
  input  logic [N_INST-1:0] inst_block_sigs,
  input  logic [N_INST-1:0] inst_idle_sigs,
  input  logic              enable,
  input  logic [CNT_W-1:0]  threshold,
  input  logic              clear,
  output logic              block,
  output logic              block_pulse,
  output logic              block_seen,
  output logic [N_TOT-1:0]  blocked_mask,
  output logic [FC_W-1:0]   first_chan,
  output logic [EVT_W-1:0]  event_count
);

  logic [N_TOT-1:0] w_vec;
  logic             w_cand;
  logic             w_progress;
  logic             w_entry;
  logic [CNT_W-1:0] w_thr_eff;
  logic [FC_W-1:0]  w_first;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [N_TOT-1:0] snap_q, snap_d;

  logic             block_q;
  logic             block_pulse_q;
  logic             block_seen_q;
  logic [N_TOT-1:0] blocked_mask_q;
  logic [FC_W-1:0]  first_chan_q;
  logic [EVT_W-1:0] event_count_q;

  assign w_vec      = {inst_block_sigs, axis_block_sigs};
  assign w_cand     = enable & (|w_vec) & ~(&inst_idle_sigs);
  assign w_progress = (w_vec != snap_q);
  assign w_thr_eff  = (threshold == '0) ? CNT_W'(1) : threshold;

  stall_prio_enc #(
    .W     (N_TOT),
    .IDX_W (FC_W)
  ) u_prio_enc (
    .vec_i   (w_vec),
    .first_o (w_first)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    snap_d  = snap_q;
    case (state_q)
      ST_IDLE: begin
        if (w_cand) begin
          state_d = ST_WATCH;
          cnt_d   = CNT_W'(1);
          snap_d  = w_vec;
        end else begin
          cnt_d   = '0;
        end
      end
      ST_WATCH: begin
        if (!w_cand) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          if (w_progress) begin
            cnt_d  = CNT_W'(1);
            snap_d = w_vec;
          end else if (cnt_q != '1) begin
            cnt_d  = cnt_q + CNT_W'(1);
          end
          // Threshold is compared live, so lowering it mid-watch fires at once.
          if (cnt_d >= w_thr_eff) state_d = ST_BLOCKED;
        end
      end
      ST_BLOCKED: begin
        if (!w_cand || w_progress) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign w_entry = (state_q == ST_WATCH) && (state_d == ST_BLOCKED);

  always_ff @(posedge kernel_monitor_clock or posedge kernel_monitor_reset) begin
    if (kernel_monitor_reset) begin
      state_q        <= ST_IDLE;
      cnt_q          <= '0;
      snap_q         <= '0;
      block_q        <= 1'b0;
      block_pulse_q  <= 1'b0;
      block_seen_q   <= 1'b0;
      blocked_mask_q <= '0;
      first_chan_q   <= '0;
      event_count_q  <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      snap_q        <= snap_d;
      block_q       <= (state_d == ST_BLOCKED);
      block_pulse_q <= w_entry;
      // An entry in the same cycle as clear counts as the first new event.
      if (w_entry) begin
        blocked_mask_q <= w_vec;
        first_chan_q   <= w_first;
        block_seen_q   <= 1'b1;
        if (clear)
          event_count_q <= EVT_W'(1);
        else if (event_count_q != '1)
          event_count_q <= event_count_q + EVT_W'(1);
      end else if (clear) begin
        block_seen_q  <= 1'b0;
        event_count_q <= '0;
      end
    end
  end

  assign block        = block_q;
  assign block_pulse  = block_pulse_q;
  assign block_seen   = block_seen_q;
  assign blocked_mask = blocked_mask_q;
  assign first_chan   = first_chan_q;
  assign event_count  = event_count_q;

endmodule
`default_nettype wire

// File: doc/deadlock_stall_watchdog.md
DEADLOCK_STALL_WATCHDOG -- requirements
Module: deadlock_stall_watchdog

Interface
REQ-001 Parameter N_AXIS, 4, number of AXIS blocking-sense channels (1..32).
REQ-002 Parameter N_INST, 4, number of monitored sub-instances (1..32).
REQ-003 Parameter CNT_W, 16, width of the persistence counter and the threshold.
REQ-004 Parameter EVT_W, 8, width of the event counter.
REQ-005 kernel_monitor_clock  in  1  sole clock; all state updates on its rising edge.
REQ-006 kernel_monitor_reset  in  1  reset, asynchronous and active-high.
REQ-007 axis_block_sigs  in  N_AXIS  1 = channel stalled on its AXIS handshake this cycle.
REQ-008 inst_block_sigs  in  N_INST  1 = instance internally blocked.
REQ-009 inst_idle_sigs  in  N_INST  1 = instance idle.
REQ-010 enable  in  1  0 forces IDLE and holds the counter at 0.
REQ-011 threshold  in  CNT_W  cycles of unchanged stall required to declare a block; 0 behaves as 1.
REQ-012 clear  in  1  single-cycle clear of sticky status and event counter.
REQ-013 block  out  1  high while in BLOCKED.
REQ-014 block_pulse  out  1  one-cycle pulse on entry into BLOCKED.
REQ-015 block_seen  out  1  sticky; set on any BLOCKED entry.
REQ-016 blocked_mask  out  N_AXIS+N_INST  {inst_block_sigs, axis_block_sigs} captured at entry.
REQ-017 first_chan  out  $clog2(N_AXIS+N_INST)  lowest set index of the captured mask.
REQ-018 event_count  out  EVT_W  saturating count of BLOCKED entries.

Function
REQ-019 Candidate = enable & (|axis_block_sigs | |inst_block_sigs) & ~(&inst_idle_sigs), evaluated combinationally each cycle.
REQ-020 Snapshot = registered {inst_block_sigs, axis_block_sigs}; "progress" = current vector differs from snapshot.
REQ-021 States: IDLE, WATCH, BLOCKED.
REQ-022 IDLE -> WATCH when candidate; counter loads 1, snapshot loads current vector.
REQ-023 WATCH: candidate & no progress -> counter +1 (saturating at all-ones); candidate & progress -> counter reloads 1, snapshot updates; ~candidate -> IDLE, counter 0.
REQ-024 WATCH -> BLOCKED in the cycle the next counter value >= max(threshold,1); threshold 1 gives block asserted one cycle after candidate first seen.
REQ-025 On BLOCKED entry: block_pulse=1 for exactly one cycle, blocked_mask and first_chan captured from the current vector, block_seen set, event_count +1 saturating at 2^EVT_W-1.
REQ-026 BLOCKED -> IDLE when ~candidate or progress; block drops the following cycle; captured mask/first_chan retained until next entry.
REQ-027 threshold is sampled live; lowering it mid-WATCH below the counter triggers entry next cycle.
REQ-028 enable=0 in any state: next state IDLE, counter 0; sticky outputs untouched.
REQ-029 clear and BLOCKED entry in the same cycle: entry wins; block_seen=1, event_count=1.
REQ-030 clear alone: block_seen=0, event_count=0; blocked_mask/first_chan unchanged.
REQ-031 All outputs registered; no combinational input-to-output path.

Reset
REQ-032 Reset asserted at any time, including mid-WATCH or BLOCKED, forces IDLE, counter 0, snapshot 0, block=0, block_pulse=0, block_seen=0, blocked_mask=0, first_chan=0, event_count=0.
REQ-033 First candidate evaluation occurs on the first rising edge after reset deasserts.

Structure
REQ-034 Package deadlock_mon_pkg holds the state enum and default values of N_AXIS, N_INST, CNT_W, EVT_W.
REQ-035 One sub-module, stall_prio_enc: parameterised lowest-index-first priority encoder producing first_chan.

Verification
REQ-036 threshold=4, axis_block_sigs=4'b0010 steady, inst_idle=0 -> block_pulse on 4th cycle after onset, first_chan=1, event_count=1.
REQ-037 threshold=4, vector toggles 4'b0010/4'b0100 every 2 cycles -> block never asserts.
REQ-038 All inst_idle_sigs=1 with axis_block_sigs=4'b1111 for 100 cycles -> block stays 0.
REQ-039 Blocked with inst_block_sigs[2]=1 (N_AXIS=4), then clear in entry cycle of a second event -> block_seen=1, event_count=1, first_chan=6.
REQ-040 Reset asserted mid-BLOCKED -> all outputs 0 immediately (asynchronously); 256 entries with EVT_W=8 -> event_count holds 255.
